// File: rtl/lc3_memory.sv
// LC-3 unified word memory with independent instruction and data ports.
// Each port runs its own IDLE/BUSY/RESP handshake with a fixed latency, and a
// backdoor load port preloads the array.
module lc3_memory #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned I_LAT  = 1,
   parameter int unsigned D_LAT  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       pc,
   input  logic              instrmem_rd,
   output logic [15:0]       Instr_dout,
   output logic              complete_instr,
   input  logic              D_macc,
   input  logic              Data_rd,
   input  logic [15:0]       Data_addr,
   input  logic [15:0]       Data_din,
   output logic [15:0]       Data_dout,
   output logic              complete_data,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [15:0]       load_data
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   localparam logic [3:0] I_CNT_INIT = 4'(I_LAT - 1);
   localparam logic [3:0] D_CNT_INIT = 4'(D_LAT - 1);

   logic [15:0] mem [2**ADDR_W];

   state_t            i_state_q, i_state_d;
   logic [3:0]        i_cnt_q, i_cnt_d;
   logic [ADDR_W-1:0] i_addr_q, i_addr_d;
   logic [ADDR_W-1:0] i_acc_addr;
   logic              i_enter_resp;

   state_t            d_state_q, d_state_d;
   logic [3:0]        d_cnt_q, d_cnt_d;
   logic [ADDR_W-1:0] d_addr_q, d_addr_d;
   logic              d_rd_q, d_rd_d;
   logic [15:0]       d_din_q, d_din_d;
   logic [ADDR_W-1:0] d_acc_addr;
   logic              d_acc_rd;
   logic [15:0]       d_acc_din;
   logic              d_enter_resp;

   // Upper address bits alias onto the array and are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};

   // Instruction port next-state; in IDLE the live inputs address the access
   // so a single-cycle latency can respond on the sampling edge.
   always_comb begin
      i_state_d    = i_state_q;
      i_cnt_d      = i_cnt_q;
      i_addr_d     = i_addr_q;
      i_acc_addr   = i_addr_q;
      i_enter_resp = 1'b0;
      unique case (i_state_q)
         StIdle: begin
            if (instrmem_rd) begin
               i_addr_d   = pc[ADDR_W-1:0];
               i_acc_addr = pc[ADDR_W-1:0];
               if (I_CNT_INIT == 4'd0) begin
                  i_state_d    = StResp;
                  i_enter_resp = 1'b1;
               end else begin
                  i_state_d = StBusy;
                  i_cnt_d   = I_CNT_INIT;
               end
            end
         end
         StBusy: begin
            if (!instrmem_rd) begin
               i_state_d = StIdle;
               i_cnt_d   = 4'd0;
            end else if (i_cnt_q <= 4'd1) begin
               i_state_d    = StResp;
               i_cnt_d      = 4'd0;
               i_enter_resp = 1'b1;
            end else begin
               i_cnt_d = i_cnt_q - 4'd1;
            end
         end
         StResp:  i_state_d = StIdle;
         default: i_state_d = StIdle;
      endcase
   end

   // Data port next-state; same handshake, also carrying direction and write data.
   always_comb begin
      d_state_d    = d_state_q;
      d_cnt_d      = d_cnt_q;
      d_addr_d     = d_addr_q;
      d_rd_d       = d_rd_q;
      d_din_d      = d_din_q;
      d_acc_addr   = d_addr_q;
      d_acc_rd     = d_rd_q;
      d_acc_din    = d_din_q;
      d_enter_resp = 1'b0;
      unique case (d_state_q)
         StIdle: begin
            if (D_macc) begin
               d_addr_d   = Data_addr[ADDR_W-1:0];
               d_rd_d     = Data_rd;
               d_din_d    = Data_din;
               d_acc_addr = Data_addr[ADDR_W-1:0];
               d_acc_rd   = Data_rd;
               d_acc_din  = Data_din;
               if (D_CNT_INIT == 4'd0) begin
                  d_state_d    = StResp;
                  d_enter_resp = 1'b1;
               end else begin
                  d_state_d = StBusy;
                  d_cnt_d   = D_CNT_INIT;
               end
            end
         end
         StBusy: begin
            if (!D_macc) begin
               d_state_d = StIdle;
               d_cnt_d   = 4'd0;
            end else if (d_cnt_q <= 4'd1) begin
               d_state_d    = StResp;
               d_cnt_d      = 4'd0;
               d_enter_resp = 1'b1;
            end else begin
               d_cnt_d = d_cnt_q - 4'd1;
            end
         end
         StResp:  d_state_d = StIdle;
         default: d_state_d = StIdle;
      endcase
   end

   // Port state, captured request fields and registered read data.
   always_ff @(posedge clock) begin
      if (reset) begin
         i_state_q  <= StIdle;
         i_cnt_q    <= 4'd0;
         i_addr_q   <= '0;
         d_state_q  <= StIdle;
         d_cnt_q    <= 4'd0;
         d_addr_q   <= '0;
         d_rd_q     <= 1'b0;
         d_din_q    <= 16'h0000;
         Instr_dout <= 16'h0000;
         Data_dout  <= 16'h0000;
      end else begin
         i_state_q <= i_state_d;
         i_cnt_q   <= i_cnt_d;
         i_addr_q  <= i_addr_d;
         d_state_q <= d_state_d;
         d_cnt_q   <= d_cnt_d;
         d_addr_q  <= d_addr_d;
         d_rd_q    <= d_rd_d;
         d_din_q   <= d_din_d;
         if (i_enter_resp) begin
            Instr_dout <= mem[i_acc_addr];
         end
         if (d_enter_resp && d_acc_rd) begin
            Data_dout <= mem[d_acc_addr];
         end
      end
   end

   // Array writes: reads above see the pre-edge value; the later load write
   // wins over a same-word data write. Reset gates only the data port.
   always_ff @(posedge clock) begin
      if (!reset && d_enter_resp && !d_acc_rd) begin
         mem[d_acc_addr] <= d_acc_din;
      end
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign complete_instr = (i_state_q == StResp);
   assign complete_data  = (d_state_q == StResp);

endmodule

// File: tb/tb_lc3_memory.sv
// Self-checking bench for lc3_memory: directed vectors and corner sequences,
// then randomized dual-port traffic against a transaction-level model.
module tb_lc3_memory;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned I_LAT  = 1;
   localparam int unsigned D_LAT  = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic        instrmem_rd;
   logic [15:0] Instr_dout;
   logic        complete_instr;
   logic        D_macc;
   logic        Data_rd;
   logic [15:0] Data_addr;
   logic [15:0] Data_din;
   logic [15:0] Data_dout;
   logic        complete_data;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;

   // Second instance with a 3-cycle data latency for the mid-access drop case.
   logic        d3_macc;
   logic        d3_rd;
   logic [15:0] d3_addr;
   logic [15:0] d3_din;
   logic [15:0] d3_dout;
   logic        d3_comp;
   logic [15:0] d3_idout;
   logic        d3_icomp;

   always #5 clock = ~clock;

   lc3_memory #(.ADDR_W(ADDR_W), .I_LAT(I_LAT), .D_LAT(D_LAT)) u_dut (
      .clock(clock), .reset(reset),
      .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout),
      .complete_instr(complete_instr),
      .D_macc(D_macc), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
      .Data_dout(Data_dout), .complete_data(complete_data),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   lc3_memory #(.ADDR_W(ADDR_W), .I_LAT(1), .D_LAT(3)) u_dut3 (
      .clock(clock), .reset(reset),
      .pc(16'h0000), .instrmem_rd(1'b0), .Instr_dout(d3_idout),
      .complete_instr(d3_icomp),
      .D_macc(d3_macc), .Data_rd(d3_rd), .Data_addr(d3_addr), .Data_din(d3_din),
      .Data_dout(d3_dout), .complete_data(d3_comp),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   int checks = 0;
   int errors = 0;
   logic [15:0] ref_mem [256];

   typedef struct {
      logic [15:0] pc;
      logic [15:0] exp;
      string       name;
   } ivec_t;
   ivec_t vecs[5];

   function automatic logic [15:0] pat(input int k);
      return 16'((k * 257) ^ 16'h5A3C);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [7:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      ref_mem[a] = d;
      tick();
      load_en = 1'b0;
   endtask

   initial begin
      int i_free, d_free, i_resp, d_resp;
      bit i_pend, d_pend, d_wr, exp_ic, exp_dc;
      logic [7:0]  i_a, d_a;
      logic [15:0] d_dc, h_i, h_d;

      reset = 1'b1; pc = '0; instrmem_rd = 0; D_macc = 0; Data_rd = 0; Data_addr = '0;
      Data_din = '0; load_en = 0; load_addr = '0; load_data = '0;
      d3_macc = 0; d3_rd = 0; d3_addr = '0; d3_din = '0;
      tick(); tick();
      chk("rst_idout", Instr_dout, 16'h0000);
      chk("rst_ddout", Data_dout, 16'h0000);
      chk("rst_ci", 16'(complete_instr), 16'h0);
      chk("rst_cd", 16'(complete_data), 16'h0);

      // Preload while reset is still high.
      for (int k = 0; k < 256; k++) do_load(8'(k), pat(k));
      do_load(8'h03, 16'h1234);
      reset = 1'b0;
      tick();

      vecs[0] = '{16'h3003, 16'h1234, "pc3003"};
      vecs[1] = '{16'h1105, pat(5), "alias1105"};
      vecs[2] = '{16'hFFFF, pat(255), "pcFFFF"};
      vecs[3] = '{16'h0000, pat(0), "pc0000"};
      vecs[4] = '{16'hAB80, pat(128), "aliasAB80"};
      for (int v = 0; v < 5; v++) begin
         pc = vecs[v].pc;
         instrmem_rd = 1'b1;
         tick();
         chk({vecs[v].name, "_ci"}, 16'(complete_instr), 16'h1);
         chk({vecs[v].name, "_dout"}, Instr_dout, vecs[v].exp);
         instrmem_rd = 1'b0;
         tick();
         chk({vecs[v].name, "_ci_low"}, 16'(complete_instr), 16'h0);
      end

      // Held instruction request: complete alternates 1,0 at full throughput.
      pc = 16'h3003; instrmem_rd = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("held_ci", 16'(complete_instr), 16'((c % 2) == 0));
         chk("held_dout", Instr_dout, 16'h1234);
      end
      instrmem_rd = 1'b0; tick();

      // Data write then read, 2-cycle latency.
      Data_addr = 16'h0010; Data_din = 16'hBEEF; Data_rd = 1'b0; D_macc = 1'b1;
      tick(); chk("wr_cd_c1", 16'(complete_data), 16'h0);
      tick(); chk("wr_cd_c2", 16'(complete_data), 16'h1);
      chk("wr_dout_hold", Data_dout, 16'h0000);
      ref_mem[8'h10] = 16'hBEEF;
      D_macc = 1'b0; tick();
      chk("wr_cd_off", 16'(complete_data), 16'h0);
      Data_rd = 1'b1; D_macc = 1'b1;
      tick(); chk("rd_cd_c1", 16'(complete_data), 16'h0);
      tick(); chk("rd_cd_c2", 16'(complete_data), 16'h1);
      chk("rd_beef", Data_dout, 16'hBEEF);
      D_macc = 1'b0; tick();

      // Drop during BUSY on the 3-cycle instance: no complete, no write.
      d3_addr = 16'h0010; d3_din = 16'hDEAD; d3_rd = 1'b0; d3_macc = 1'b1;
      tick();
      d3_macc = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick(); chk("drop_no_cd", 16'(d3_comp), 16'h0);
      end
      d3_rd = 1'b1; d3_macc = 1'b1;
      tick(); chk("d3_rd_c1", 16'(d3_comp), 16'h0);
      tick(); chk("d3_rd_c2", 16'(d3_comp), 16'h0);
      tick(); chk("d3_rd_c3", 16'(d3_comp), 16'h1);
      chk("drop_old_val", d3_dout, pat(16));
      d3_macc = 1'b0; tick();

      // Same-edge instruction read and data write to 0x20: read-before-write.
      do_load(8'h20, 16'h0001);
      Data_addr = 16'h0020; Data_din = 16'h0002; Data_rd = 1'b0; D_macc = 1'b1;
      tick();
      pc = 16'h0020; instrmem_rd = 1'b1;
      tick();
      chk("rbw_ci", 16'(complete_instr), 16'h1);
      chk("rbw_cd", 16'(complete_data), 16'h1);
      chk("rbw_old", Instr_dout, 16'h0001);
      ref_mem[8'h20] = 16'h0002;
      instrmem_rd = 1'b0; D_macc = 1'b0; tick();
      instrmem_rd = 1'b1; tick();
      chk("rbw_new", Instr_dout, 16'h0002);
      instrmem_rd = 1'b0; tick();

      // Reset during data BUSY aborts the write; load still works under reset.
      Data_addr = 16'h0040; Data_din = 16'hFFFF; Data_rd = 1'b0; D_macc = 1'b1;
      tick();
      chk("abort_busy_cd", 16'(complete_data), 16'h0);
      chk("abort_pre_dout", Data_dout, 16'hBEEF);
      reset = 1'b1; D_macc = 1'b0;
      do_load(8'h41, 16'h7777);
      chk("abort_idout", Instr_dout, 16'h0000);
      chk("abort_ddout", Data_dout, 16'h0000);
      chk("abort_cd", 16'(complete_data), 16'h0);
      chk("abort_ci", 16'(complete_instr), 16'h0);
      reset = 1'b0;
      tick(); chk("abort_cd_p1", 16'(complete_data), 16'h0);
      tick(); chk("abort_cd_p2", 16'(complete_data), 16'h0);
      Data_rd = 1'b1; D_macc = 1'b1;
      tick(); tick();
      chk("abort_rd_cd", 16'(complete_data), 16'h1);
      chk("abort_mem_kept", Data_dout, pat(16'h40));
      D_macc = 1'b0; tick();
      pc = 16'h0041; instrmem_rd = 1'b1; tick();
      chk("load_in_rst", Instr_dout, 16'h7777);
      instrmem_rd = 1'b0; tick();

      // Request held through reset deassertion starts fresh on the first edge.
      pc = 16'h0005; instrmem_rd = 1'b1; reset = 1'b1;
      tick(); chk("rst_held_ci", 16'(complete_instr), 16'h0);
      chk("rst_held_dout", Instr_dout, 16'h0000);
      reset = 1'b0;
      tick(); chk("post_rst_ci", 16'(complete_instr), 16'h1);
      chk("post_rst_dout", Instr_dout, pat(5));
      instrmem_rd = 1'b0; tick();

      // Randomized dual-port traffic against the transaction model.
      i_free = 0; d_free = 0; i_resp = 0; d_resp = 0;
      i_pend = 0; d_pend = 0; d_wr = 0; i_a = '0; d_a = '0; d_dc = '0;
      h_i = pat(5); h_d = 16'h0000;
      for (int e = 0; e < 400; e++) begin
         if (!i_pend) instrmem_rd = ($urandom_range(0, 2) != 0);
         pc = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
         if (!d_pend) D_macc = ($urandom_range(0, 2) != 0);
         Data_rd   = 1'($urandom_range(0, 1));
         Data_addr = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
         Data_din  = 16'($urandom);
         load_en   = ($urandom_range(0, 7) == 0);
         load_addr = 8'($urandom_range(0, 15));
         load_data = 16'($urandom);

         if (!i_pend && e >= i_free && instrmem_rd) begin
            i_pend = 1; i_a = pc[7:0]; i_resp = e + int'(I_LAT) - 1;
         end
         if (!d_pend && e >= d_free && D_macc) begin
            d_pend = 1; d_a = Data_addr[7:0]; d_wr = !Data_rd; d_dc = Data_din;
            d_resp = e + int'(D_LAT) - 1;
         end
         exp_ic = 0; exp_dc = 0;
         if (i_pend && i_resp == e) begin
            exp_ic = 1; h_i = ref_mem[i_a]; i_pend = 0; i_free = e + 2;
         end
         if (d_pend && d_resp == e) begin
            exp_dc = 1;
            if (!d_wr) h_d = ref_mem[d_a];
            d_pend = 0; d_free = e + 2;
         end
         if (exp_dc && d_wr) ref_mem[d_a] = d_dc;
         if (load_en) ref_mem[load_addr] = load_data;

         tick();
         chk("rnd_ci", 16'(complete_instr), 16'(exp_ic));
         chk("rnd_cd", 16'(complete_data), 16'(exp_dc));
         chk("rnd_idout", Instr_dout, h_i);
         chk("rnd_ddout", Data_dout, h_d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_memory.md
LC3_MEMORY -- requirements
Module: lc3_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the word-address width; depth is 2**ADDR_W 16-bit words.
REQ-002 SHALL have parameter I_LAT, default 1, giving instruction-port latency in cycles; legal range 1..15.
REQ-003 SHALL have parameter D_LAT, default 2, giving data-port latency in cycles; legal range 1..15.
REQ-004 Ports: clock  in  1  single clock; all logic on its rising edge.
REQ-005 Ports: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: pc  in  16  instruction address; instrmem_rd  in  1  instruction request; Instr_dout  out  16  instruction word; complete_instr  out  1  instruction done.
REQ-007 Ports: D_macc  in  1  data request; Data_rd  in  1  1=read, 0=write; Data_addr  in  16; Data_din  in  16  write data from core; Data_dout  out  16  read data; complete_data  out  1  data done.
REQ-008 Ports: load_en  in  1; load_addr  in  ADDR_W; load_data  in  16; bench backdoor preload port.

Function
REQ-009 SHALL hold two independent port FSMs (instruction, data), each with states IDLE, BUSY, RESP, over a dual-port word array.
REQ-010 SHALL use only the low ADDR_W bits of pc and Data_addr; upper bits are ignored (aliasing wraps).
REQ-011 In IDLE, a request high at an edge SHALL capture the address (and, for data, Data_rd and Data_din), load the latency counter with LAT-1, and enter BUSY, or enter RESP directly when LAT=1.
REQ-012 In BUSY, the counter SHALL decrement each cycle; at 0 the FSM enters RESP on the next edge.
REQ-013 complete_instr/complete_data SHALL be high for exactly the one cycle the FSM is in RESP; first complete occurs LAT cycles after the request-sampling edge.
REQ-014 RESP SHALL always return to IDLE on the next edge; a request still high is re-sampled in IDLE, so maximum throughput is one access per LAT+1 cycles.
REQ-015 Instr_dout/Data_dout SHALL be registered, updated with mem[captured address] on entry to RESP, and hold their value until the next RESP.
REQ-016 A data write SHALL commit mem[captured address] <= captured Data_din on the edge entering RESP; Data_dout is unchanged for writes.
REQ-017 If the request drops while BUSY, the FSM SHALL return to IDLE on the next edge with no complete pulse and no write.
REQ-018 Request-signal changes during BUSY other than drop (address/data changes) SHALL be ignored; captured values are used.
REQ-019 Same-edge instruction read and data write to the same word SHALL return the old value to the instruction port (read-before-write).
REQ-020 load_en SHALL write load_data to mem[load_addr] on the edge; it has priority over a same-edge data-port write to the same word.
REQ-021 The ports SHALL never stall one another; both may complete in the same cycle.

Reset
REQ-022 While reset is high at an edge, both FSMs SHALL go to IDLE, counters to 0, complete_instr=0, complete_data=0, Instr_dout=16'h0000, Data_dout=16'h0000.
REQ-023 Reset SHALL NOT clear the memory array; load_en SHALL remain functional during reset.
REQ-024 Reset mid-access SHALL abort it: no complete pulse, no write, and a request held high through deassertion starts a fresh access on the first edge after reset deasserts.

Verification
REQ-025 Preload mem[0x03]=16'h1234, I_LAT=1, pc=0x3003, instrmem_rd held -> complete_instr high the cycle after sampling, Instr_dout=16'h1234, then low one cycle, repeating.
REQ-026 D_LAT=2, write Data_addr=0x0010, Data_din=16'hBEEF, then read 0x0010 -> write complete 2 cycles after request, read returns Data_dout=16'hBEEF, 2 cycles after its request.
REQ-027 D_macc dropped one cycle after sampling (D_LAT=3) -> no complete_data, mem[0x10] unchanged (re-read returns old value).
REQ-028 Same edge: instruction read and data write to 0x20 (old 16'h0001, new 16'h0002) -> Instr_dout=16'h0001; next instruction read returns 16'h0002.
REQ-029 Reset asserted during data BUSY -> outputs 0, complete_data never pulses for that access, memory retains preloaded contents.
REQ-030 pc=0x1105 with ADDR_W=8 -> returns mem[0x05].
